// File: rtl/sram_mem_controller_pkg.sv
// Shared types and default geometry for the SRAM-backed MEM stage.
// Holds the FSM state type and the bus/timing defaults.
package sram_mem_controller_pkg;

  localparam int DATA_W      = 32;
  localparam int SRAM_DW     = 16;
  localparam int SRAM_AW     = 18;
  localparam int BASE_ADDR   = 1024;
  localparam int WAIT_CYCLES = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_DONE
  } state_e;

endpackage

// File: rtl/sram_mem_controller.sv
// Splits 32-bit loads/stores into two 16-bit async SRAM accesses.
// Ports: clk, rst (async active-low), rd_en/wr_en/address/write_data
// request in; read_data/ready out; sram_* drive the external SRAM.
module sram_mem_controller
  import sram_mem_controller_pkg::*;
#(
  parameter int DW   = DATA_W,
  parameter int SDW  = SRAM_DW,
  parameter int SAW  = SRAM_AW,
  parameter int BASE = BASE_ADDR,
  parameter int WAIT = WAIT_CYCLES
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rd_en,
  input  logic           wr_en,
  input  logic [DW-1:0]  address,
  input  logic [DW-1:0]  write_data,
  output logic [DW-1:0]  read_data,
  output logic           ready,
  output logic [SAW-1:0] sram_addr,
  output logic [SDW-1:0] sram_dq_out,
  output logic           sram_dq_oe,
  input  logic [SDW-1:0] sram_dq_in,
  output logic           sram_we_n
);

  localparam int CW = $clog2(WAIT + 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           st_q, st_d;
  logic [SAW-2:0] word_q, word_d;
  logic [SDW-1:0] wdhi_q, wdhi_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic [SAW-1:0] addr_q, addr_d;
  logic [SDW-1:0] dq_q, dq_d;
  logic           oe_q, oe_d;
  logic           we_n_q, we_n_d;

  logic [SAW-2:0] req_word;
  logic           req;
  logic           last;
  logic           pre_last;

  // Half-word pair index; wraps silently outside the mapped window.
  assign req_word = (SAW-1)'((address - DW'(BASE)) >> 2);
  assign req      = rd_en | wr_en;
  assign last     = (cnt_q == CW'(WAIT));
  // WE rises one cycle early so data/address hold past the strobe.
  assign pre_last = (cnt_q == CW'(WAIT - 1));

  assign read_data   = rdata_q;
  assign sram_addr   = addr_q;
  assign sram_dq_out = dq_q;
  assign sram_dq_oe  = oe_q;
  assign sram_we_n   = we_n_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    st_d    = st_q;
    word_d  = word_q;
    wdhi_d  = wdhi_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    dq_d    = dq_q;
    oe_d    = oe_q;
    we_n_d  = we_n_q;
    ready   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ready = ~req;
        if (req) begin
          state_d = S_LO;
          cnt_d   = '0;
          st_d    = wr_en;
          word_d  = req_word;
          wdhi_d  = write_data[DW-1:SDW];
          addr_d  = {req_word, 1'b0};
          dq_d    = write_data[SDW-1:0];
          oe_d    = wr_en;
          we_n_d  = ~wr_en;
        end
      end
      S_LO: begin
        if (last) begin
          if (!st_q) rdata_d[SDW-1:0] = sram_dq_in;
          state_d = S_HI;
          cnt_d   = '0;
          addr_d  = {word_q, 1'b1};
          dq_d    = wdhi_q;
          we_n_d  = ~st_q;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          we_n_d = we_n_q | pre_last;
        end
      end
      S_HI: begin
        if (last) begin
          if (!st_q) rdata_d[DW-1:SDW] = sram_dq_in;
          state_d = S_DONE;
          cnt_d   = '0;
          oe_d    = 1'b0;
          we_n_d  = 1'b1;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          we_n_d = we_n_q | pre_last;
        end
      end
      S_DONE: begin
        ready   = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      st_q    <= 1'b0;
      word_q  <= '0;
      wdhi_q  <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      dq_q    <= '0;
      oe_q    <= 1'b0;
      we_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
      word_q  <= word_d;
      wdhi_q  <= wdhi_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      dq_q    <= dq_d;
      oe_q    <= oe_d;
      we_n_q  <= we_n_d;
    end
  end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Self-checking bench for sram_mem_controller.
// Timeline model of each access plus an SRAM device model.
module tb_sram_mem_controller;
  import sram_mem_controller_pkg::*;

  localparam int W    = WAIT_CYCLES;
  localparam int LAST = 2 * W + 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;

  int tests = 0;
  int fails = 0;
  int lowcnt = 0;

  always #5 clk = ~clk;

  sram_mem_controller dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_in (sram_dq_in),
    .sram_we_n  (sram_we_n)
  );

  // SRAM device: async read, write captured while WE is low.
  logic [15:0] dev [0:262143];
  initial for (int i = 0; i < 262144; i++) dev[i] = 16'h0;
  assign sram_dq_in = dev[sram_addr];
  always @(posedge clk)
    if (!sram_we_n && sram_dq_oe) dev[sram_addr] <= sram_dq_out;

  // Reference model: c counts cycles since a request was accepted.
  int          c;
  bit          m_st;
  logic [31:0] m_wd;
  logic [31:0] m_last;
  logic [16:0] m_word;
  logic [15:0] mmem [int];

  function automatic logic [15:0] rdm(input int k);
    if (mmem.exists(k)) return mmem[k];
    return 16'h0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      c = 0;
      m_last = 32'h0;
    end else if (c == 0) begin
      if (rd_en | wr_en) begin
        c = 1;
        m_st = wr_en;
        m_wd = write_data;
        m_word = 17'((address - 32'd1024) >> 2);
        if (wr_en) begin
          mmem[int'({m_word, 1'b0})] = write_data[15:0];
          mmem[int'({m_word, 1'b1})] = write_data[31:16];
        end
      end
    end else if (c == LAST) begin
      c = 0;
    end else begin
      c++;
      if (c == LAST && !m_st)
        m_last = {rdm(int'({m_word, 1'b1})), rdm(int'({m_word, 1'b0}))};
    end
  end

  always @(negedge clk) begin
    logic e_rdy, e_we, e_oe, ok;
    logic [17:0] e_addr;
    logic [15:0] e_dq;
    int half, pos;
    if (rst) begin
      e_rdy = 1'b0; e_we = 1'b1; e_oe = 1'b0;
      e_addr = sram_addr; e_dq = sram_dq_out;
      if (c == 0) e_rdy = !(rd_en | wr_en);
      else if (c == LAST) e_rdy = 1'b1;
      else begin
        half = (c - 1) / (W + 1);
        pos  = (c - 1) % (W + 1);
        e_addr = {m_word, half[0]};
        e_oe = m_st;
        e_we = !(m_st && pos != W);
        if (m_st) e_dq = half ? m_wd[31:16] : m_wd[15:0];
      end
      ok = (ready === e_rdy) && (sram_we_n === e_we) &&
           (sram_dq_oe === e_oe) && (sram_addr === e_addr) &&
           (sram_dq_out === e_dq);
      if (c == 0 || c == LAST) ok = ok && (read_data === m_last);
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL cycle c=%0d: got rdy%b we%b oe%b a%h dq%h rd%h exp rdy%b we%b oe%b a%h dq%h rd%h",
                 c, ready, sram_we_n, sram_dq_oe, sram_addr, sram_dq_out, read_data,
                 e_rdy, e_we, e_oe, e_addr, e_dq, m_last);
      end
    end
  end

  always @(negedge clk) if (rst && !ready) lowcnt++;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic op(input logic r, input logic w, input logic [31:0] a,
                    input logic [31:0] d, output int stalls,
                    output logic [7:0] wpat, output logic [31:0] rdone);
    rd_en = r; wr_en = w; address = a; write_data = d;
    stalls = 0; wpat = 8'h0; rdone = 32'hx;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready) begin
        rdone = read_data;
        break;
      end
      if (stalls < 8) wpat[stalls] = sram_we_n;
      stalls++;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  int          st;
  logic [7:0]  wp;
  logic [31:0] rv;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; rd_en = 1'b1; wr_en = 1'b1;
    address = 32'd1024; write_data = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    chk("rst_read_data", read_data, 32'h0);
    chk("rst_sram_addr", 32'(sram_addr), 32'h0);
    chk("rst_dq_out", 32'(sram_dq_out), 32'h0);
    chk("rst_oe", 32'(sram_dq_oe), 32'h0);
    chk("rst_we_n", 32'(sram_we_n), 32'h1);
    idle();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready_after", 32'(ready), 32'h1);
    @(posedge clk); #1;

    op(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, st, wp, rv);
    idle();
    chk("st1_stalls", st, 5);
    chk("st1_we_pattern", 32'(wp), 32'h15);
    chk("st1_dev0", 32'(dev[0]), 32'hBEEF);
    chk("st1_dev1", 32'(dev[1]), 32'hDEAD);

    op(1'b1, 1'b0, 32'd1024, 32'h0, st, wp, rv);
    idle();
    chk("ld1_stalls", st, 5);
    chk("ld1_we_pattern", 32'(wp), 32'h1F);
    chk("ld1_data", rv, 32'hDEADBEEF);
    @(negedge clk);
    chk("ld1_hold", read_data, 32'hDEADBEEF);
    @(posedge clk); #1;

    op(1'b0, 1'b1, 32'd1028, 32'h12345678, st, wp, rv);
    idle();
    chk("st2_dev2", 32'(dev[2]), 32'h5678);
    chk("st2_dev3", 32'(dev[3]), 32'h1234);
    chk("st2_rd_untouched", read_data, 32'hDEADBEEF);
    op(1'b1, 1'b0, 32'd1028, 32'h0, st, wp, rv);
    idle();
    chk("ld2_data", rv, 32'h12345678);
    op(1'b1, 1'b0, 32'd1024, 32'h0, st, wp, rv);
    idle();
    chk("ld3_data", rv, 32'hDEADBEEF);

    lowcnt = 0;
    op(1'b0, 1'b1, 32'd1032, 32'hAABBCCDD, st, wp, rv);
    op(1'b1, 1'b0, 32'd1032, 32'h0, st, wp, rv);
    idle();
    repeat (3) @(negedge clk);
    chk("b2b_low_cycles", lowcnt, 10);
    chk("b2b_load", rv, 32'hAABBCCDD);
    chk("b2b_dev4", 32'(dev[4]), 32'hCCDD);
    @(posedge clk); #1;

    op(1'b1, 1'b1, 32'd1036, 32'h0F0E0D0C, st, wp, rv);
    idle();
    chk("both_we_pattern", 32'(wp), 32'h15);
    chk("both_dev6", 32'(dev[6]), 32'h0D0C);
    chk("both_dev7", 32'(dev[7]), 32'h0F0E);
    chk("both_rd_untouched", read_data, 32'hAABBCCDD);

    op(1'b0, 1'b1, 32'd1020, 32'h55667788, st, wp, rv);
    idle();
    chk("wrap_lo", 32'(dev[18'h3FFFE]), 32'h7788);
    chk("wrap_hi", 32'(dev[18'h3FFFF]), 32'h5566);

    rd_en = 1'b0; wr_en = 1'b1;
    address = 32'd1040; write_data = 32'h99998888;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("abort_pre_we_n", 32'(sram_we_n), 32'h1);
    chk("abort_pre_oe", 32'(sram_dq_oe), 32'h1);
    chk("abort_pre_addr", 32'(sram_addr), 32'd9);
    rst = 1'b0;
    idle();
    #1;
    chk("abort_we_n", 32'(sram_we_n), 32'h1);
    chk("abort_oe", 32'(sram_dq_oe), 32'h0);
    chk("abort_addr", 32'(sram_addr), 32'h0);
    chk("abort_ready", 32'(ready), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ready_after", 32'(ready), 32'h1);
    chk("abort_rd_cleared", read_data, 32'h0);
    @(posedge clk); #1;

    op(1'b1, 1'b0, 32'd1028, 32'h0, st, wp, rv);
    idle();
    chk("post_abort_load", rv, 32'h12345678);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
